// File: rtl/activation_step_controller_if.sv
// activation_step_controller_if: element-side bus (mp_valid/mp_ready, act_en/act_clear/threshold/step_idx, out_valid/out_ready)
interface activation_step_controller_if #(
  parameter int DATA_WIDTH = 16,
  parameter int STEP_WIDTH = 8
);
  logic mp_valid;
  logic mp_ready;
  logic act_en;
  logic act_clear;
  logic [DATA_WIDTH-1:0] threshold;
  logic [STEP_WIDTH-1:0] step_idx;
  logic out_valid;
  logic out_ready;
  modport master (
    input  mp_valid, out_ready,
    output mp_ready, act_en, act_clear, threshold, step_idx, out_valid
  );
  modport slave (
    output mp_valid, out_ready,
    input  mp_ready, act_en, act_clear, threshold, step_idx, out_valid
  );
endinterface

// File: rtl/activation_step_controller.sv
// activation_step_controller: clear -> num_steps handshaked timesteps -> drain -> readout pass; ports clk/rstn, start/abort/num_steps/threshold_in in, busy/done out, element bus via master modport
module activation_step_controller #(
  parameter int DATA_WIDTH  = 16,
  parameter int STEP_WIDTH  = 8,
  parameter int ACC_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic                  abort,
  input  logic [STEP_WIDTH-1:0] num_steps,
  input  logic [DATA_WIDTH-1:0] threshold_in,
  output logic                  busy,
  output logic                  done,
  activation_step_controller_if.master bus
);
  localparam int CW = $clog2(ACC_LATENCY + 1);
  typedef enum logic [2:0] {IDLE, CLEAR, RUN, DRAIN, OUTPUT, DONE} state_t;
  state_t state, state_n;
  logic [STEP_WIDTH-1:0] n_q, step_q;
  logic [DATA_WIDTH-1:0] thr_q;
  logic [CW-1:0] cnt_q;
  logic hs, last;
  assign last = step_q == n_q - 1'b1;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state  <= IDLE;
      n_q    <= '0;
      thr_q  <= '0;
      step_q <= '0;
      cnt_q  <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && start) begin
        n_q   <= num_steps;
        thr_q <= threshold_in;
      end
      if (state == CLEAR) step_q <= '0;
      else if (hs) step_q <= step_q + 1'b1;
      if (hs && last) cnt_q <= CW'(ACC_LATENCY - 1);
      else if (state == DRAIN) cnt_q <= cnt_q - 1'b1;
    end
  always_comb begin
    state_n = state;
    hs = 1'b0;
    if (state == IDLE) state_n = start ? CLEAR : IDLE;
    else if (abort) state_n = IDLE;
    else
      case (state)
        CLEAR:  state_n = n_q == '0 ? DONE : RUN;
        RUN: begin
          hs = bus.mp_valid;
          state_n = hs && last ? DRAIN : RUN;
        end
        DRAIN:  state_n = cnt_q == '0 ? OUTPUT : DRAIN;
        OUTPUT: state_n = bus.out_ready ? DONE : OUTPUT;
        default: state_n = IDLE;
      endcase
  end
  assign bus.mp_ready  = state == RUN && !abort;
  assign bus.act_en    = hs;
  assign bus.act_clear = state == CLEAR || (state != IDLE && abort);
  assign bus.threshold = thr_q;
  assign bus.step_idx  = step_q;
  assign bus.out_valid = state == OUTPUT;
  assign busy = state != IDLE;
  assign done = state == DONE && !abort;
endmodule

// File: tb/tb_activation_step_controller.sv
// tb_activation_step_controller: directed pass table, reset/abort sequences and random stimulus against a pass-level model
module tb_activation_step_controller;
  localparam int LAT = 2;
  logic clk = 1'b0, rstn = 1'b0, start = 1'b0, abort = 1'b0;
  logic [7:0] num_steps = '0;
  logic [15:0] threshold_in = '0;
  logic busy, done;
  activation_step_controller_if #(.DATA_WIDTH(16), .STEP_WIDTH(8)) bus ();
  activation_step_controller #(.DATA_WIDTH(16), .STEP_WIDTH(8), .ACC_LATENCY(LAT)) dut (
    .clk(clk), .rstn(rstn), .start(start), .abort(abort), .num_steps(num_steps),
    .threshold_in(threshold_in), .busy(busy), .done(done), .bus(bus)
  );
  always #5 clk = ~clk;
  typedef struct {
    string name;
    int n;
    logic [15:0] pat;
    int ordy_from;
    int exp_pulses;
    int exp_done;
    int exp_ov;
  } vec_t;
  vec_t vt[6];
  int vectors = 0, miscompares = 0, cyc = 0;
  bit m_act = 0, m_cl = 0, m_handed = 0;
  int m_n = 0, m_taken = 0, m_drained = 0;
  logic [15:0] m_thr = '0;
  logic o_en, o_done, o_ov, o_clr, o_busy;
  function automatic logic [4:0] ph();
    logic clr, run, drn, outp, dn;
    clr  = m_act && !m_cl;
    run  = m_act && m_cl && m_taken < m_n;
    drn  = m_act && m_cl && m_n > 0 && m_taken == m_n && m_drained < LAT;
    outp = m_act && m_cl && m_n > 0 && m_taken == m_n && m_drained == LAT && !m_handed;
    dn   = m_act && m_cl && (m_n == 0 || m_handed);
    return {clr, run, drn, outp, dn};
  endfunction
  task automatic check(input string tag);
    logic [4:0] p;
    logic [29:0] e, a;
    p = ph();
    e = {p[3] && !abort, p[3] && bus.mp_valid && !abort, p[4] || (m_act && abort), p[1], m_act,
         p[0] && !abort, m_thr, 8'(m_taken)};
    a = {bus.mp_ready, bus.act_en, bus.act_clear, bus.out_valid, busy, done, bus.threshold, bus.step_idx};
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, a, e);
    end
  endtask
  task automatic cmp(input string tag, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
    end
  endtask
  task automatic advance();
    logic [4:0] p;
    p = ph();
    if (!m_act) begin
      if (start) begin
        m_act = 1; m_cl = 0; m_n = num_steps; m_thr = threshold_in; m_drained = 0; m_handed = 0;
      end
    end else if (p[4]) begin
      m_taken = 0;
      if (abort) m_act = 0; else m_cl = 1;
    end else if (abort) m_act = 0;
    else if (p[3]) begin if (bus.mp_valid) m_taken++; end
    else if (p[2]) m_drained++;
    else if (p[1]) begin if (bus.out_ready) m_handed = 1; end
    else m_act = 0;
  endtask
  task automatic step(input logic s, a, v, r, input logic [7:0] n, input logic [15:0] t, input string tag);
    start = s; abort = a; bus.mp_valid = v; bus.out_ready = r; num_steps = n; threshold_in = t;
    #1 check(tag);
    o_en = bus.act_en; o_done = done; o_ov = bus.out_valid; o_clr = bus.act_clear; o_busy = busy;
    @(posedge clk);
    advance();
    @(negedge clk);
    cyc++;
  endtask
  task automatic run_pass(input vec_t v, input int budget);
    int pulses = 0, ovc = 0, dc = -1;
    logic [15:0] th;
    th = 16'($urandom);
    for (int c = 0; c < budget && dc < 0; c++) begin
      step(c == 0, 1'b0, v.pat[c % 16], c >= v.ordy_from, 8'(v.n), th, v.name);
      pulses += int'(o_en);
      ovc += int'(o_ov);
      if (o_done) dc = c;
    end
    cmp({v.name, "_pulses"}, pulses, v.exp_pulses);
    cmp({v.name, "_done_cycle"}, dc, v.exp_done);
    cmp({v.name, "_out_valid_cycles"}, ovc, v.exp_ov);
  endtask
  initial begin
    vec_t rp;
    vt[0] = '{"nominal",      4,   16'hFFFF, 0,  4,   9,   1};
    vt[1] = '{"stall",        3,   16'h00A4, 0,  3,   11,  1};
    vt[2] = '{"backpressure", 2,   16'hFFFF, 11, 2,   12,  6};
    vt[3] = '{"zero_steps",   0,   16'hFFFF, 0,  0,   2,   0};
    vt[4] = '{"one_step",     1,   16'hFFFF, 0,  1,   6,   1};
    vt[5] = '{"max_steps",    255, 16'hFFFF, 0,  255, 260, 1};
    bus.mp_valid = 1'b0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    #1 check("reset_state");
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 6; i++) run_pass(vt[i], 400);
    step(1'b1, 1'b0, 1'b1, 1'b1, 8'd8, 16'h1234, "rst_run");
    for (int c = 1; c < 5; c++) step(1'b0, 1'b0, 1'b1, 1'b1, 8'd8, 16'h1234, "rst_run");
    cmp("rst_step_idx", int'(bus.step_idx), 3);
    rstn = 1'b0;
    m_act = 0; m_cl = 0; m_taken = 0; m_thr = '0;
    #1 check("reset_mid_run");
    @(negedge clk);
    rstn = 1'b1;
    rp = '{"after_reset", 8, 16'hFFFF, 0, 8, 13, 1};
    run_pass(rp, 100);
    step(1'b1, 1'b0, 1'b1, 1'b1, 8'd5, 16'h0F0F, "abort_run");
    for (int c = 1; c < 4; c++) step(1'b0, 1'b0, 1'b1, 1'b1, 8'd5, 16'h0F0F, "abort_run");
    cmp("abort_step_idx", int'(bus.step_idx), 2);
    step(1'b0, 1'b1, 1'b1, 1'b1, 8'd5, 16'h0F0F, "abort_cycle");
    cmp("abort_act_en", int'(o_en), 0);
    cmp("abort_act_clear", int'(o_clr), 1);
    cmp("abort_done", int'(o_done), 0);
    step(1'b0, 1'b0, 1'b1, 1'b1, 8'd5, 16'h0F0F, "after_abort");
    cmp("after_abort_busy", int'(o_busy), 0);
    cmp("after_abort_done", int'(o_done), 0);
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 3) == 0, $urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 2) != 0, 8'($urandom_range(0, 6)), 16'($urandom), "random");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
